// File: rtl/vmem_pkg.sv
// rtl/vmem_pkg.sv - shared types for the vector memory router
package vmem_pkg;

    localparam int DEF_LANES  = 6;
    localparam int DEF_LANE_W = 8;

    typedef enum logic [1:0] {
        REG_RAM,
        REG_VRAM,
        REG_ERR
    } region_e;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_e;

    // Lane vector at the default geometry; lane 0 occupies the low bits.
    typedef logic [DEF_LANES-1:0][DEF_LANE_W-1:0] lane_vec_t;

endpackage

// File: rtl/vmem_region_decode.sv
// rtl/vmem_region_decode.sv - address to region and memory address decode
//
// Purpose: classifies a CPU byte address as RAM, VRAM or illegal and
//          extracts the address forwarded to the selected memory.
// Ports:   addr_i   - CPU byte address
//          region_o - decoded region
//          maddr_o  - low address bits forwarded to the memory
module vmem_region_decode
    import vmem_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int MEM_AW     = 17,
    parameter int REGION_BIT = 17
) (
    input  logic [ADDR_W-1:0] addr_i,
    output region_e           region_o,
    output logic [MEM_AW-1:0] maddr_o
);

    logic [ADDR_W-1:0] upper;

    always_comb begin
        // Any bit above the region select makes the access illegal.
        upper = addr_i >> (REGION_BIT + 1);
        if (upper != '0) begin
            region_o = REG_ERR;
        end else if (addr_i[REGION_BIT]) begin
            region_o = REG_VRAM;
        end else begin
            region_o = REG_RAM;
        end
        maddr_o = addr_i[MEM_AW-1:0];
    end

endmodule

// File: rtl/vmem_router.sv
// rtl/vmem_router.sv - vector load/store router between CPU, RAM and VRAM
//
// Purpose: accepts one vector load/store at a time, strobes the decoded
//          memory, waits the read latency and returns one response pulse.
// Ports:   clk, rst                     - clock, synchronous active-high reset
//          req_*                        - CPU request (valid/ready handshake)
//          rsp_valid/rsp_rdata/rsp_err  - one-cycle response
//          ram_*                        - CPU RAM port
//          vram_*                       - VRAM CPU-side port
//          vga_busy                     - VGA owns VRAM (VRAM_SHARED = 1 only)
module vmem_router
    import vmem_pkg::*;
#(
    parameter int LANES       = 6,
    parameter int LANE_W      = 8,
    parameter int ADDR_W      = 32,
    parameter int MEM_AW      = 17,
    parameter int REGION_BIT  = 17,
    parameter int RD_LAT      = 1,
    parameter int VRAM_SHARED = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_we,
    input  logic [ADDR_W-1:0]       req_addr,
    input  logic [LANES*LANE_W-1:0] req_wdata,
    input  logic [LANES-1:0]        req_mask,
    output logic                    rsp_valid,
    output logic [LANES*LANE_W-1:0] rsp_rdata,
    output logic                    rsp_err,
    output logic [LANES-1:0]        ram_we,
    output logic [MEM_AW-1:0]       ram_addr,
    output logic [LANES*LANE_W-1:0] ram_wd,
    input  logic [LANES*LANE_W-1:0] ram_rd,
    output logic [LANES-1:0]        vram_we,
    output logic [MEM_AW-1:0]       vram_addr,
    output logic [LANES*LANE_W-1:0] vram_wd,
    input  logic [LANES*LANE_W-1:0] vram_rd,
    input  logic                    vga_busy
);

    localparam int DW = LANES * LANE_W;

    state_e             state_q;
    logic [2:0]         cnt_q;
    logic               we_q;
    region_e            region_q;
    logic [LANES-1:0]   mask_q;
    logic               rsp_valid_q;
    logic               rsp_err_q;
    logic [LANES-1:0]   ram_we_q;
    logic [LANES-1:0]   vram_we_q;
    logic [MEM_AW-1:0]  ram_addr_q;
    logic [MEM_AW-1:0]  vram_addr_q;
    logic [DW-1:0]      ram_wd_q;
    logic [DW-1:0]      vram_wd_q;

    region_e            dec_region;
    logic [MEM_AW-1:0]  dec_maddr;
    logic               accept;
    logic [DW-1:0]      sel_rd;
    logic [DW-1:0]      rdata_c;

    vmem_region_decode #(
        .ADDR_W     (ADDR_W),
        .MEM_AW     (MEM_AW),
        .REGION_BIT (REGION_BIT)
    ) u_decode (
        .addr_i   (req_addr),
        .region_o (dec_region),
        .maddr_o  (dec_maddr)
    );

    // VGA ownership blocks all acceptance, whatever the target region.
    assign req_ready = (state_q == IDLE) && !rst && !((VRAM_SHARED != 0) && vga_busy);
    assign accept    = req_valid && req_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            region_q    <= REG_RAM;
            mask_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            ram_we_q    <= '0;
            vram_we_q   <= '0;
            ram_addr_q  <= '0;
            vram_addr_q <= '0;
            ram_wd_q    <= '0;
            vram_wd_q   <= '0;
        end else begin
            // Strobes and the response are single-cycle pulses.
            ram_we_q    <= '0;
            vram_we_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q  <= ISSUE;
                        we_q     <= req_we;
                        region_q <= dec_region;
                        mask_q   <= req_mask;
                        // Port outputs are loaded here so they are valid
                        // throughout ISSUE; an illegal access touches neither.
                        if (dec_region == REG_RAM) begin
                            ram_addr_q <= dec_maddr;
                            ram_wd_q   <= req_wdata;
                            if (req_we) ram_we_q <= req_mask;
                        end
                        if (dec_region == REG_VRAM) begin
                            vram_addr_q <= dec_maddr;
                            vram_wd_q   <= req_wdata;
                            if (req_we) vram_we_q <= req_mask;
                        end
                    end
                end
                ISSUE: begin
                    if (we_q || region_q == REG_ERR || RD_LAT <= 1) begin
                        state_q     <= RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= (region_q == REG_ERR);
                    end else begin
                        state_q <= WAIT;
                        cnt_q   <= 3'(RD_LAT - 1);
                    end
                end
                WAIT: begin
                    cnt_q <= cnt_q - 3'd1;
                    if (cnt_q == 3'd1) begin
                        state_q     <= RESP;
                        rsp_valid_q <= 1'b1;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Read data arrives RD_LAT cycles after the address, which lines up with
    // the RESP cycle, so it is steered through combinationally.
    always_comb begin
        sel_rd  = (region_q == REG_VRAM) ? vram_rd : ram_rd;
        rdata_c = '0;
        if (rsp_valid_q && !we_q && region_q != REG_ERR) begin
            for (int i = 0; i < LANES; i++) begin
                if (mask_q[i]) rdata_c[i*LANE_W +: LANE_W] = sel_rd[i*LANE_W +: LANE_W];
            end
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rdata_c;
    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wd    = ram_wd_q;
    assign vram_we   = vram_we_q;
    assign vram_addr = vram_addr_q;
    assign vram_wd   = vram_wd_q;

endmodule
